time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/time_set_pkg.sv | 21 ++
 rtl/button_debounce.sv | 44 ++++
 rtl/time_set_controller.sv | 144 ++++++++++++++
 tb/tb_time_set_controller.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/time_set_pkg.sv
// Shared types and default constants for the time-set controller.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } set_state_t;

  typedef enum logic {
    MIN,
    HOUR
  } owner_t;

  localparam int TICKS_PER_MIN_DEF = 12000;
  localparam int DEBOUNCE_CYC_DEF  = 4;
  localparam int REPEAT_DELAY_DEF  = 100;
  localparam int REPEAT_PERIOD_DEF = 20;
  localparam int PRESC_W           = 14;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer followed by a level debouncer for one raw push button.
module button_debounce
  import time_set_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);

  localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // NOTE: non-blocking assignments make every flop see pre-edge values, which the sync chain relies on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      // Any sample that agrees with the current level restarts the run.
      if (sync2 != level) begin
        if (cnt == CNT_MAX) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Minute prescaler plus button-driven set FSM with auto-repeat for a clock sequencer.
// Optional: SECONDS_CLEAR_ON_SET_EN makes each minute-set pulse restart the prescaler.
module time_set_controller
  import time_set_pkg::*;
#(
  parameter int TICKS_PER_MIN = TICKS_PER_MIN_DEF,
  parameter int DEBOUNCE_CYC  = DEBOUNCE_CYC_DEF,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic Clock,
  input  logic nReset,
  input  logic BtnMin,
  input  logic BtnHour,
  output logic Tick,
  output logic SyncMinOut,
  output logic SyncHourOut,
  output logic Setting
);

  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0]      DELAY_MAX  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0]      PERIOD_MAX = RW'(REPEAT_PERIOD - 1);
  localparam logic [PRESC_W-1:0] TICK_MAX   = PRESC_W'(TICKS_PER_MIN - 1);

  logic min_level;
  logic hour_level;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_min_db (
    .clk   (Clock),
    .rst_n (nReset),
    .raw   (BtnMin),
    .level (min_level)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_hour_db (
    .clk   (Clock),
    .rst_n (nReset),
    .raw   (BtnHour),
    .level (hour_level)
  );

  set_state_t         state_q, state_d;
  owner_t             owner_q, owner_d;
  logic [RW-1:0]      rep_cnt_q, rep_cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_pend_q, tick_pend_d;
  logic               pulse;
  logic               owner_level;
  logic               sync_min_d, sync_hour_d, tick_d;
  logic               wrap, tick_req;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rep_cnt_d   = rep_cnt_q;
    pulse       = 1'b0;
    owner_level = (owner_q == HOUR) ? hour_level : min_level;

    case (state_q)
      IDLE: begin
        // HOUR is tested first so it wins a simultaneous press.
        if (hour_level) begin
          state_d   = HOLD;
          owner_d   = HOUR;
          rep_cnt_d = '0;
          pulse     = 1'b1;
        end else if (min_level) begin
          state_d   = HOLD;
          owner_d   = MIN;
          rep_cnt_d = '0;
          pulse     = 1'b1;
        end
      end
      HOLD: begin
        if (!owner_level) begin
          state_d = IDLE;
        end else if (rep_cnt_q == DELAY_MAX) begin
          state_d   = REPEAT;
          rep_cnt_d = '0;
          pulse     = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!owner_level) begin
          state_d = IDLE;
        end else if (rep_cnt_q == PERIOD_MAX) begin
          rep_cnt_d = '0;
          pulse     = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    sync_min_d  = pulse && (owner_d == MIN);
    sync_hour_d = pulse && (owner_d == HOUR);

    // A tick that collides with a set pulse slips one cycle via tick_pend.
    wrap        = (presc_q == TICK_MAX);
    presc_d     = wrap ? '0 : presc_q + 1'b1;
    tick_req    = wrap || tick_pend_q;
    tick_d      = tick_req && !pulse;
    tick_pend_d = tick_req && pulse;
`ifdef SECONDS_CLEAR_ON_SET_EN
    if (sync_min_d) begin
      presc_d     = '0;
      tick_d      = 1'b0;
      tick_pend_d = 1'b0;
    end
`else
`endif
  end

  always_ff @(posedge Clock) begin
    if (!nReset) begin
      state_q     <= IDLE;
      owner_q     <= MIN;
      rep_cnt_q   <= '0;
      presc_q     <= '0;
      tick_pend_q <= 1'b0;
      Tick        <= 1'b0;
      SyncMinOut  <= 1'b0;
      SyncHourOut <= 1'b0;
      Setting     <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rep_cnt_q   <= rep_cnt_d;
      presc_q     <= presc_d;
      tick_pend_q <= tick_pend_d;
      Tick        <= tick_d;
      SyncMinOut  <= sync_min_d;
      SyncHourOut <= sync_hour_d;
      Setting     <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller: edge numbers count from the first edge after reset release.
module tb_time_set_controller;

  logic Clock = 1'b0;
  logic nReset;
  logic BtnMin;
  logic BtnHour;
  logic Tick;
  logic SyncMinOut;
  logic SyncHourOut;
  logic Setting;

  time_set_controller dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .BtnMin      (BtnMin),
    .BtnHour     (BtnHour),
    .Tick        (Tick),
    .SyncMinOut  (SyncMinOut),
    .SyncHourOut (SyncHourOut),
    .Setting     (Setting)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_no;
  int tick_at[16];
  int min_at[16];
  int hour_at[16];
  int n_tick, n_min, n_hour;
  int set_rise, set_fall, excl_viol;
  logic set_prev;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
    edge_no++;
    if (Tick === 1'b1) begin
      if (n_tick < 16) tick_at[n_tick] = edge_no;
      n_tick++;
    end
    if (SyncMinOut === 1'b1) begin
      if (n_min < 16) min_at[n_min] = edge_no;
      n_min++;
    end
    if (SyncHourOut === 1'b1) begin
      if (n_hour < 16) hour_at[n_hour] = edge_no;
      n_hour++;
    end
    if (SyncMinOut === 1'b1 && SyncHourOut === 1'b1) excl_viol++;
    if (Tick === 1'b1 && (SyncMinOut === 1'b1 || SyncHourOut === 1'b1)) excl_viol++;
    if (Setting === 1'b1 && !set_prev && set_rise < 0) set_rise = edge_no;
    if (Setting !== 1'b1 && set_prev) set_fall = edge_no;
    set_prev = (Setting === 1'b1);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    for (int i = 0; i < 16; i++) begin
      tick_at[i] = -1;
      min_at[i]  = -1;
      hour_at[i] = -1;
    end
    n_tick = 0; n_min = 0; n_hour = 0;
    set_rise = -1; set_fall = -1; excl_viol = 0; set_prev = 1'b0;
    edge_no = 0;
  endtask

  task automatic do_reset(input string tag);
    nReset = 1'b0; BtnMin = 1'b0; BtnHour = 1'b0;
    steps(2);
    check({tag, ".tick"}, int'(Tick), 0);
    check({tag, ".sync_min"}, int'(SyncMinOut), 0);
    check({tag, ".sync_hour"}, int'(SyncHourOut), 0);
    check({tag, ".setting"}, int'(Setting), 0);
    nReset = 1'b1;
    clear_log();
  endtask

  int exp_hour[7] = '{7, 107, 127, 147, 167, 187, 207};

  initial begin
    edge_no = 0;
    clear_log();

    // Free-running prescaler, no buttons.
    do_reset("rst0");
    steps(24005);
    check("idle.n_tick", n_tick, 2);
    check("idle.tick0", tick_at[0], 12000);
    check("idle.tick1", tick_at[1], 24000);
    check("idle.n_sync", n_min + n_hour, 0);

    // Glitch of 3 samples is shorter than the debounce run.
    do_reset("rst1");
    BtnMin = 1'b1;
    steps(3);
    BtnMin = 1'b0;
    steps(20);
    check("glitch.n_min", n_min, 0);
    check("glitch.set_rise", set_rise, -1);

    // Hour held across edges 1..201; edge 202 is the first low sample.
    do_reset("rst2");
    BtnHour = 1'b1;
    steps(201);
    BtnHour = 1'b0;
    steps(20);
    check("repeat.n_hour", n_hour, 7);
    for (int i = 0; i < 7; i++) check($sformatf("repeat.hour[%0d]", i), hour_at[i], exp_hour[i]);
    check("repeat.n_min", n_min, 0);
    check("repeat.set_rise", set_rise, 7);
    check("repeat.set_fall", set_fall, 208);
    check("repeat.excl", excl_viol, 0);

    // Simultaneous press: hour wins, a single pulse.
    do_reset("rst3");
    BtnMin = 1'b1; BtnHour = 1'b1;
    steps(50);
    BtnMin = 1'b0; BtnHour = 1'b0;
    steps(20);
    check("both.n_hour", n_hour, 1);
    check("both.hour0", hour_at[0], 7);
    check("both.n_min", n_min, 0);
    check("both.excl", excl_viol, 0);

    // Non-owner min held while hour owns; taken as new press once back in IDLE.
    do_reset("rst4");
    BtnHour = 1'b1;
    steps(19);
    BtnMin = 1'b1;
    steps(11);
    BtnHour = 1'b0;
    steps(10);
    BtnMin = 1'b0;
    steps(20);
    check("handoff.n_hour", n_hour, 1);
    check("handoff.hour0", hour_at[0], 7);
    check("handoff.n_min", n_min, 1);
    check("handoff.min0", min_at[0], 38);

    // Minute pulse lands where the prescaler holds its last count.
    do_reset("rst5");
    steps(11993);
    BtnMin = 1'b1;
    steps(7);
    BtnMin = 1'b0;
    steps(30);
    check("collide.n_min", n_min, 1);
    check("collide.min0", min_at[0], 12000);
    check("collide.n_hour", n_hour, 0);
`ifdef SECONDS_CLEAR_ON_SET_EN
    check("collide.n_tick_early", n_tick, 0);
    steps(12000);
    check("collide.n_tick", n_tick, 1);
    check("collide.tick0", tick_at[0], 24000);
`else
    check("collide.n_tick", n_tick, 1);
    check("collide.tick0", tick_at[0], 12001);
`endif
    check("collide.excl", excl_viol, 0);

    // One-cycle reset in the middle of REPEAT, button still held.
    do_reset("rst6");
    BtnHour = 1'b1;
    steps(120);
    nReset = 1'b0;
    step();
    check("midrst.tick", int'(Tick), 0);
    check("midrst.sync_min", int'(SyncMinOut), 0);
    check("midrst.sync_hour", int'(SyncHourOut), 0);
    check("midrst.setting", int'(Setting), 0);
    nReset = 1'b1;
    steps(20);
    BtnHour = 1'b0;
    steps(20);
    check("midrst.n_hour", n_hour, 3);
    check("midrst.hour1", hour_at[1], 107);
    check("midrst.hour2", hour_at[2], 128);
    check("midrst.n_min", n_min, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
